// File: rtl/seq_divider_n.sv
// Multi-cycle restoring integer divider, one quotient bit per clock, with
// signed/unsigned mode, start/busy/done handshake and divide-by-zero flag.
module seq_divider_n #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             dbz_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic             qbit_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Most-negative maps onto 2^(WIDTH-1), which is representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return twos_neg(v);
        end else begin
            return v;
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = (divisor == {WIDTH{1'b0}}) ? FIX : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = RUN;
                end
            end
            FIX:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    always_comb begin
        shift_s  = {rem_r, dvd_r[WIDTH-1]};
        trial_s  = shift_s - {1'b0, dvs_r};
        rem_nx_s = rem_r;
        qbit_s   = 1'b0;
        if (trial_s[WIDTH]) begin
            rem_nx_s = shift_s[WIDTH-1:0];
            qbit_s   = 1'b0;
        end else begin
            rem_nx_s = trial_s[WIDTH-1:0];
            qbit_s   = 1'b1;
        end
    end

    // Sign correction and divide-by-zero result selection.
    always_comb begin
        q_fix_s = quo_r;
        r_fix_s = rem_r;
        if (dbz_r) begin
            q_fix_s = {WIDTH{1'b1}};
            r_fix_s = dvd_r;
        end else begin
            q_fix_s = neg_q_r ? twos_neg(quo_r) : quo_r;
            r_fix_s = neg_r_r ? twos_neg(rem_r) : rem_r;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt_r       <= {CW{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_nx_s != IDLE);
            done <= (state_r == FIX);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        neg_q_r <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_r <= signed_op & dividend[WIDTH-1];
                        dbz_r   <= (divisor == {WIDTH{1'b0}});
                        // RUN is skipped on a zero divisor, so the raw dividend
                        // is parked here to be returned as the remainder.
                        dvd_r   <= (divisor == {WIDTH{1'b0}}) ? dividend
                                                              : magnitude(dividend, signed_op);
                        dvs_r   <= magnitude(divisor, signed_op);
                        rem_r   <= {WIDTH{1'b0}};
                        quo_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    rem_r <= rem_nx_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    quo_r <= {quo_r[WIDTH-2:0], qbit_s};
                    cnt_r <= cnt_r + CW'(1);
                end
                FIX: begin
                    quotient    <= q_fix_s;
                    remainder   <= r_fix_s;
                    div_by_zero <= dbz_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_n.sv
// Self-checking bench for seq_divider_n: 32-bit and 8-bit instances checked
// against an arithmetic reference model.
module tb_seq_divider_n;

    logic        clk = 1'b0;
    logic        r;
    logic        start, signed_op;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        busy, done, div_by_zero;
    logic        start8, signed_op8;
    logic [7:0]  dividend8, divisor8, quotient8, remainder8;
    logic        busy8, done8, div_by_zero8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider_n #(.WIDTH(32)) dut (
        .clk(clk), .r(r), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    seq_divider_n #(.WIDTH(8)) dut8 (
        .clk(clk), .r(r), .start(start8), .signed_op(signed_op8),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
        .quotient(quotient8), .remainder(remainder8), .div_by_zero(div_by_zero8)
    );

    // Reference: plain integer division on 64-bit values, truncated to w bits.
    function automatic void ref_div(input int w, input bit s, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] rm, output bit z);
        longint sa, sb, qq, rr, mask;
        mask = (longint'(1) << w) - 1;
        z = (b == 32'd0);
        if (z) begin
            q  = 32'(mask);
            rm = a;
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
            if (s && a[w-1]) sa = sa - (longint'(1) << w);
            if (s && b[w-1]) sb = sb - (longint'(1) << w);
            qq = sa / sb;
            rr = sa % sb;
            q  = 32'(qq & mask);
            rm = 32'(rr & mask);
        end
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output bit done_at_start);
        @(negedge clk);
        done_at_start = done;
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~s;
        lat = 0; busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        @(negedge clk);
        start8 = 1'b1; signed_op8 = s; dividend8 = a; divisor8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; dividend8 = 8'($urandom); divisor8 = 8'($urandom);
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        r = 1'b0;
        start = 1'b0; signed_op = 1'b0; dividend = 32'd0; divisor = 32'd0;
        start8 = 1'b0; signed_op8 = 1'b0; dividend8 = 8'd0; divisor8 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            fails++;
            $display("FAIL reset32: got busy=%b done=%b dbz=%b q=%h r=%h, expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        tests++;
        if ({busy8, done8, div_by_zero8, quotient8, remainder8} !== 19'd0) begin
            fails++;
            $display("FAIL reset8: got busy=%b done=%b q=%h r=%h, expected all 0",
                     busy8, done8, quotient8, remainder8);
        end
        @(negedge clk);
        r = 1'b1;
    endtask

    task automatic test_vector(input string name, input bit s, input logic [31:0] a,
                               input logic [31:0] b);
        logic [31:0] eq, er;
        bit ez, das;
        int lat, bc, elat, ebc;
        ref_div(32, s, a, b, eq, er, ez);
        elat = ez ? 1 : 33;
        ebc  = ez ? 1 : 33;
        run32(s, a, b, lat, bc, das);
        tests++;
        if (lat != elat) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        tests++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            fails++;
            $display("FAIL %s result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                     name, quotient, remainder, div_by_zero, eq, er, ez);
        end
        tests++;
        if (bc != ebc || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: got %0d busy cycles, busy@done=%b expected %0d, 0",
                     name, bc, busy, ebc);
        end
    endtask

    task automatic test_directed();
        test_vector("unsigned_basic", 1'b0, 32'd57821254, 32'd5468);
        tests++;
        if (quotient !== 32'd10574 || remainder !== 32'd2622) begin
            fails++;
            $display("FAIL basic_const: got q=%0d r=%0d expected 10574 2622", quotient, remainder);
        end
        test_vector("signed_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        tests++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL m7_2_const: got q=%h r=%h expected fffffffd ffffffff", quotient, remainder);
        end
        test_vector("signed_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        test_vector("unsigned_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        test_vector("dbz_unsigned", 1'b0, 32'd100, 32'd0);
        test_vector("dbz_signed", 1'b1, 32'd100, 32'd0);
        tests++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd100 || div_by_zero !== 1'b1) begin
            fails++;
            $display("FAIL dbz_const: got q=%h r=%0d z=%b expected ffffffff 100 1",
                     quotient, remainder, div_by_zero);
        end
        test_vector("after_dbz", 1'b0, 32'd10, 32'd3);
        test_vector("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        tests++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL overflow_const: got q=%h r=%h z=%b expected 80000000 0 0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            test_vector("random32", 1'($urandom_range(0, 1)), pick32(), pick32());
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] eq, er;
        bit ez;
        int lat;
        ref_div(32, 1'b0, 32'd1000003, 32'd977, eq, er, ez);
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000003; divisor = 32'd977;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; signed_op = 1'b1; dividend = 32'hFFFF_0000; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 33 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            fails++;
            $display("FAIL ignored_start: got lat=%0d q=%h r=%h expected lat=33 q=%h r=%h",
                     lat, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit das;
        logic [31:0] eq, er;
        bit ez;
        run32(1'b0, 32'd500, 32'd7, lat, bc, das);
        ref_div(32, 1'b1, 32'hFFFF_FC18, 32'd13, eq, er, ez);
        run32(1'b1, 32'hFFFF_FC18, 32'd13, lat, bc, das);
        tests++;
        if (das !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done_cycle: start issued with done=%b expected 1", das);
        end
        tests++;
        if (lat != 33 || quotient !== eq || remainder !== er) begin
            fails++;
            $display("FAIL b2b_result: got lat=%0d q=%h r=%h expected lat=33 q=%h r=%h",
                     lat, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd99999; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        r = 1'b0;
        #1;
        tests++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h expected all 0",
                     busy, done, quotient, remainder);
        end
        repeat (2) @(negedge clk);
        r = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL reset_mid_nodone: got %0d done pulses expected 0", pulses);
        end
        test_vector("after_reset", 1'b0, 32'd12345, 32'd67);
    endtask

    task automatic test_width8();
        logic [31:0] eq, er;
        bit ez, s;
        int lat;
        logic [7:0] a, b;
        run8(1'b0, 8'd255, 8'd1, lat);
        tests++;
        if (lat != 9 || quotient8 !== 8'd255 || remainder8 !== 8'd0) begin
            fails++;
            $display("FAIL w8_255_1: got lat=%0d q=%h r=%h expected 9 ff 00", lat, quotient8, remainder8);
        end
        run8(1'b1, 8'h80, 8'h03, lat);
        tests++;
        if (lat != 9 || quotient8 !== 8'hD6 || remainder8 !== 8'hFE) begin
            fails++;
            $display("FAIL w8_80_3: got lat=%0d q=%h r=%h expected 9 d6 fe", lat, quotient8, remainder8);
        end
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = (i % 5 == 0) ? 8'h80 : 8'($urandom);
            b = (i % 7 == 0) ? 8'h00 : ((i % 5 == 0) ? 8'hFF : 8'($urandom));
            ref_div(8, s, {24'd0, a}, {24'd0, b}, eq, er, ez);
            run8(s, a, b, lat);
            tests++;
            if (lat != (ez ? 1 : 9) || quotient8 !== eq[7:0] || remainder8 !== er[7:0]
                || div_by_zero8 !== ez) begin
                fails++;
                $display("FAIL w8_random: a=%h b=%h s=%b got lat=%0d q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         a, b, s, lat, quotient8, remainder8, div_by_zero8, eq[7:0], er[7:0], ez);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
